// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates NUM_CHUNKS signed partial sums per result and queues results in a FIFO
module psum_accumulator #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ACC_BW         = 22,
    parameter int NUM_CHUNKS     = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int CIW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int PW  = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PARTIAL_SUM_BW-1:0] in_psum,
    input  logic                      acc_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_BW-1:0]         out_sum,
    output logic [CIW-1:0]            chunk_idx,
    output logic [PW:0]               fifo_count,
    output logic                      ovf
);

    // Guard bits let the true group sum be held, so a group that wraps at an
    // intermediate add is still reported as overflowed at push time.
    localparam int WIDE = ACC_BW + CIW + 1;
    localparam logic [CIW-1:0] LAST_IDX = CIW'(NUM_CHUNKS - 1);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [WIDE-1:0]   acc;
    logic [WIDE-1:0]   acc_base;
    logic [WIDE-1:0]   psum_ext;
    logic [WIDE-1:0]   sum;
    logic [CIW-1:0]    chunk_base;
    logic              last_chunk;
    logic              sum_ovf;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ACC_BW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign in_ready  = (fifo_count != FULL_CNT) & rstn;
    assign out_valid = (fifo_count != '0);
    assign out_sum   = out_valid ? mem[rd_ptr] : '0;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // acc_clr in the same cycle as an accept restarts the group with this psum.
    assign acc_base   = acc_clr ? '0 : acc;
    assign chunk_base = acc_clr ? '0 : chunk_idx;
    assign psum_ext   = {{(WIDE - PARTIAL_SUM_BW){in_psum[PARTIAL_SUM_BW-1]}}, in_psum};
    assign sum        = acc_base + psum_ext;
    assign last_chunk = (chunk_base == LAST_IDX);
    assign push       = accept & last_chunk;
    assign sum_ovf    = (|sum[WIDE-1:ACC_BW-1]) & ~(&sum[WIDE-1:ACC_BW-1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            chunk_idx <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            if (last_chunk) begin
                acc       <= '0;
                chunk_idx <= '0;
                if (sum_ovf) begin
                    ovf <= 1'b1;
                end
            end else begin
                acc       <= sum;
                chunk_idx <= chunk_base + 1'b1;
            end
        end else if (acc_clr) begin
            acc       <= '0;
            chunk_idx <= '0;
        end
    end

    // Storage needs no reset: out_sum is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sum[ACC_BW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator with a queue-based reference model
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_psum = '0;
    logic        acc_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [21:0] out_sum;
    logic [1:0]  chunk_idx;
    logic [2:0]  fifo_count;
    logic        ovf;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [19:0] b_psum = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [20:0] b_out_sum;
    logic [1:0]  b_chunk_idx;
    logic [2:0]  b_fifo_count;
    logic        b_ovf;

    int checks = 0;
    int failures = 0;

    logic [21:0] mq[$];
    logic [21:0] exp_pop[$];
    logic [21:0] got[$];
    longint      m_sum;
    int          m_idx;
    logic        m_ovf;
    logic        m_acc;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_psum(in_psum), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .chunk_idx(chunk_idx),
        .fifo_count(fifo_count), .ovf(ovf)
    );

    psum_accumulator #(.ACC_BW(21)) dut21 (
        .clk(clk), .rstn(rstn), .in_valid(b_valid), .in_ready(b_ready),
        .in_psum(b_psum), .acc_clr(1'b0), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_sum(b_out_sum), .chunk_idx(b_chunk_idx),
        .fifo_count(b_fifo_count), .ovf(b_ovf)
    );

    task automatic model_reset();
        mq.delete();
        m_sum = 0;
        m_idx = 0;
        m_ovf = 1'b0;
    endtask

    task automatic step(input logic v, input logic [19:0] p, input logic clr, input logic ordy);
        longint base;
        longint s;
        int     idx;
        logic   m_pop;
        @(negedge clk);
        in_valid  = v;
        in_psum   = p;
        acc_clr   = clr;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) got.push_back(out_sum);
        m_pop = (mq.size() != 0) && ordy;
        m_acc = v && (mq.size() < 4);
        if (m_pop) exp_pop.push_back(mq.pop_front());
        if (m_acc) begin
            base = clr ? 0 : m_sum;
            idx  = clr ? 0 : m_idx;
            s    = base + longint'($signed(p));
            if (idx == 3) begin
                mq.push_back(s[21:0]);
                if (s > 2097151 || s < -2097152) m_ovf = 1'b1;
                m_sum = 0;
                m_idx = 0;
            end else begin
                m_sum = s;
                m_idx = idx + 1;
            end
        end else if (clr) begin
            m_sum = 0;
            m_idx = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_sum !== 22'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        checks++; if (ovf !== 1'b0 || b_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b/%b exp=0", ovf, b_ovf); end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_group();
        logic [19:0] vals [4] = '{20'd100, -20'sd30, 20'd7, 20'd1};
        int          exp_idx [4] = '{1, 2, 3, 0};
        checks++; if (chunk_idx !== 2'd0) begin failures++; $display("FAIL single_idx_start got=%0d exp=0", chunk_idx); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b1);
            checks++;
            if (chunk_idx !== 2'(exp_idx[i])) begin
                failures++; $display("FAIL single_idx[%0d] got=%0d exp=%0d", i, chunk_idx, exp_idx[i]);
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_sum !== 22'd78) begin failures++; $display("FAIL single_out_sum got=%0d exp=78", $signed(out_sum)); end
        step(1'b0, 20'd0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        got.delete();
        exp_pop.delete();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 20'd1, 1'b0, 1'b0);
            if (m_acc) sent++;
        end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL bp_full_count got=%0d exp=4", fifo_count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 20'd1, 1'b0, 1'b0);
            if (m_acc) sent++;
        end
        checks++; if (chunk_idx !== 2'd0 || fifo_count !== 3'd4) begin
            failures++; $display("FAIL bp_held idx=%0d count=%0d exp idx=0 count=4", chunk_idx, fifo_count);
        end
        for (int i = 0; i < 40 && (sent < 20 || mq.size() != 0); i++) begin
            step(sent < 20, 20'd1, 1'b0, 1'b1);
            if (m_acc) sent++;
        end
        checks++; if (got.size() != 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] !== 22'd4) begin failures++; $display("FAIL bp_val[%0d] got=%0d exp=4", i, got[i]); end
        end
    endtask

    task automatic test_clear();
        logic [19:0] pre [4] = '{20'd1, 20'd2, 20'd3, 20'd4};
        got.delete();
        for (int i = 0; i < 4; i++) step(1'b1, pre[i], 1'b0, 1'b0);
        step(1'b1, 20'd10, 1'b0, 1'b0);
        step(1'b1, 20'd20, 1'b0, 1'b0);
        step(1'b1, 20'd5, 1'b1, 1'b0);
        checks++; if (chunk_idx !== 2'd1) begin failures++; $display("FAIL clr_idx got=%0d exp=1", chunk_idx); end
        for (int i = 0; i < 3; i++) step(1'b1, 20'd1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL clr_count got=%0d exp=2", fifo_count); end
        for (int i = 0; i < 3; i++) step(1'b0, 20'd0, 1'b0, 1'b1);
        checks++; if (got.size() != 2) begin failures++; $display("FAIL clr_pops got=%0d exp=2", got.size()); end
        else begin
            checks++; if (got[0] !== 22'd10) begin failures++; $display("FAIL clr_first got=%0d exp=10", got[0]); end
            checks++; if (got[1] !== 22'd8) begin failures++; $display("FAIL clr_result got=%0d exp=8", got[1]); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); b_valid = 1'b1; b_psum = 20'h7FFFF;
        end
        @(negedge clk); b_valid = 1'b0;
        #1;
        checks++; if (b_out_valid !== 1'b1 || b_out_sum !== 21'h1FFFFC) begin
            failures++; $display("FAIL ovf_sum valid=%b got=%0d exp=-4", b_out_valid, $signed(b_out_sum));
        end
        checks++; if (b_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", b_ovf); end
        @(negedge clk); b_out_ready = 1'b1;
        @(negedge clk); b_out_ready = 1'b0;
        @(negedge clk);
        checks++; if (b_ovf !== 1'b1 || b_out_valid !== 1'b0) begin
            failures++; $display("FAIL ovf_sticky ovf=%b valid=%b exp ovf=1 valid=0", b_ovf, b_out_valid);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 20'h80000, 1'b0, 1'b0);
        checks++; if (out_sum !== 22'h200000) begin failures++; $display("FAIL neg_sum got=%0d exp=-2097152", $signed(out_sum)); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL neg_ovf got=%b exp=0", ovf); end
        step(1'b0, 20'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, 20'd1, 1'b0, 1'b0);
        step(1'b1, 20'd5, 1'b0, 1'b0);
        step(1'b1, 20'd5, 1'b0, 1'b0);
        checks++; if (chunk_idx !== 2'd2 || fifo_count !== 3'd1) begin
            failures++; $display("FAIL mid_pre idx=%0d count=%0d exp idx=2 count=1", chunk_idx, fifo_count);
        end
        @(negedge clk); in_valid = 1'b0; rstn = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0 || chunk_idx !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mid_reset count=%0d idx=%0d valid=%b rdy=%b exp 0", fifo_count, chunk_idx, out_valid, in_ready);
        end
        model_reset();
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 20'd3, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 22'd12) begin
            failures++; $display("FAIL mid_after valid=%b got=%0d exp=12", out_valid, out_sum);
        end
        step(1'b0, 20'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [21:0] head;
        got.delete();
        exp_pop.delete();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 20'($urandom()), $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            head = (mq.size() != 0) ? mq[0] : 22'd0;
            checks++;
            if (fifo_count !== 3'(mq.size()) || chunk_idx !== 2'(m_idx) || out_valid !== (mq.size() != 0) ||
                out_sum !== head || ovf !== m_ovf || in_ready !== (mq.size() < 4)) begin
                failures++;
                $display("FAIL rand[%0d] count=%0d/%0d idx=%0d/%0d sum=%0d/%0d ovf=%b/%b rdy=%b", n, fifo_count,
                         mq.size(), chunk_idx, m_idx, out_sum, head, ovf, m_ovf, in_ready);
            end
        end
        checks++; if (got != exp_pop) begin failures++; $display("FAIL rand_stream got=%0d exp=%0d items", got.size(), exp_pop.size()); end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_backpressure();
        test_clear();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
